mem_write: RTL and testbench
============================

MEM_WRITE -- requirements
Module: mem_write

Interface
REQ-001 SHALL have parameter LINE_BYTE_OFFSET, default 6, line size 2^LINE_BYTE_OFFSET bytes (16 words).
REQ-002 SHALL have parameter DEPTH, default 2, number of writeback queue entries.
REQ-003 SHALL have parameter AXI_ID, default 4'b0000, constant awid.
REQ-004 SHALL have port i_clk, input, 1, sole clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port i_req_valid, input, 1, a writeback request is offered.
REQ-007 SHALL have port i_req_addr, input, 32, burst start address.
REQ-008 SHALL have port i_req_len, input, 4, awlen (beats minus 1).
REQ-009 SHALL have port i_req_size, input, 3, awsize.
REQ-010 SHALL have port i_req_strb, input, 4, wstrb applied to every beat.
REQ-011 SHALL have port i_req_data, input, 32*16, line data; beat k carries word k.
REQ-012 SHALL have port o_req_ready, output, 1, queue can accept a request.
REQ-013 SHALL have port o_write_process, output, 1, at least one entry is queued or in flight.
REQ-014 SHALL have port o_write_address, output, 32, head entry address.
REQ-015 SHALL have port i_probe_addr, input, 32, line address to check for pending writes.
REQ-016 SHALL have port o_probe_hit, output, 1, i_probe_addr[31:LINE_BYTE_OFFSET] matches any valid entry.
REQ-017 SHALL have port o_bus_error, output, 1, sticky error flag (see Configuration).
REQ-018 SHALL have port axi_bus_req, output, axi_w_req, AW/W channel outputs and bready.
REQ-019 SHALL have port axi_bus_resp, input, axi_w_resp, awready, wready, bvalid, bresp, bid.

Function
REQ-020 SHALL accept a request on i_req_valid && o_req_ready; the entry becomes valid the next cycle.
REQ-021 SHALL drive o_req_ready = (registered entry count < DEPTH); it does not depend on a same-cycle pop.
REQ-022 SHALL allow push and pop in the same cycle; count unchanged; FIFO order preserved; pointers wrap modulo DEPTH.
REQ-023 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP, with RESP -> ADDR if an entry remains after the pop and RESP -> IDLE otherwise.
REQ-024 SHALL move IDLE -> ADDR on the cycle after the queue becomes non-empty.
REQ-025 SHALL, in ADDR, hold awvalid=1 with awaddr, awlen, awsize taken from the head entry, awburst=2'b01 (INCR), awid=AXI_ID, and awlock, awcache, awprot all zero, until awready.
REQ-026 SHALL, in DATA, hold wvalid=1 with wdata = head word[beat], wstrb = entry strb, and wlast = (beat == len); beat is 4-bit, cleared on entering DATA, and increments on wready.
REQ-027 SHALL NOT assert wvalid before the AW handshake completes.
REQ-028 SHALL enter RESP after the W handshake with wlast=1, and hold bready=1 only in RESP.
REQ-029 SHALL pop the head entry on bvalid in RESP; bid is ignored.
REQ-030 SHALL drive o_write_process = (count != 0) and o_write_address = head address, updated the cycle after a pop.
REQ-031 SHALL make o_probe_hit purely combinational over the valid entries, including the in-flight head.
REQ-032 SHALL, when len=0, issue a single beat with wlast=1.

Reset
REQ-033 SHALL, on i_rst, at the next edge: go to IDLE, clear count and pointers, and drop any in-flight burst.
REQ-034 SHALL hold these values after reset: awvalid=0, wvalid=0, bready=0, o_req_ready=1, o_write_process=0, o_probe_hit=0, o_bus_error=0.

Configuration
REQ-035 SHALL, when MEM_WRITE_BRESP_CHECK_EN is defined, set o_bus_error on a B handshake with bresp != 2'b00; the flag clears only on reset.
REQ-036 SHALL, when MEM_WRITE_BRESP_CHECK_EN is undefined, tie o_bus_error to 0 and ignore bresp.

Verification
REQ-037 SHALL test: push addr 0x1FC00040, len=15, with awready/wready/bvalid always 1 -> awvalid at T+2, 16 beats with wdata = words 0..15, wlast on beat 15, pop after B, o_write_process falls.
REQ-038 SHALL test: two back-to-back pushes with DEPTH=2 -> o_req_ready=0 after the second; a push in the pop cycle is accepted; entries retire in order.
REQ-039 SHALL test: wready toggled 1/0 every cycle during len=3 -> each beat is held stable until accepted, 4 beats, wlast only on beat 3.
REQ-040 SHALL test: queued 0x00001000, probe 0x0000103C -> hit=1; probe 0x00001040 -> hit=0.
REQ-041 SHALL test: i_rst asserted mid-DATA at beat 5 -> next cycle wvalid=0, IDLE, o_write_process=0.
REQ-042 SHALL test: bresp=2'b10 with the macro defined -> o_bus_error=1 and stays set; with the macro undefined -> o_bus_error=0.

Source files
------------

// File: rtl/mem_write_if.sv
// AXI write-channel bundle for mem_write: AW/W/bready request fields and slave responses.
package mem_write_pkg;

    typedef struct packed {
        logic        awvalid;
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [3:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_req;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
        logic [3:0]  bid;
    } axi_w_resp;

endpackage

interface mem_write_if;
    mem_write_pkg::axi_w_req  axi_bus_req;
    mem_write_pkg::axi_w_resp axi_bus_resp;

    modport master (output axi_bus_req, input  axi_bus_resp);
    modport slave  (input  axi_bus_req, output axi_bus_resp);
endinterface

// File: rtl/mem_write.sv
// Writeback queue draining cache lines as AXI INCR write bursts, one entry at a time.
// Optional feature: define MEM_WRITE_BRESP_CHECK_EN to raise a sticky o_bus_error on non-OKAY bresp.
module mem_write
    import mem_write_pkg::*;
#(
    parameter int unsigned LINE_BYTE_OFFSET = 6,
    parameter int unsigned DEPTH            = 2,
    parameter logic [3:0]  AXI_ID           = 4'b0000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req_valid,
    input  logic [31:0]  i_req_addr,
    input  logic [3:0]   i_req_len,
    input  logic [2:0]   i_req_size,
    input  logic [3:0]   i_req_strb,
    input  logic [511:0] i_req_data,
    output logic         o_req_ready,
    output logic         o_write_process,
    output logic [31:0]  o_write_address,
    input  logic [31:0]  i_probe_addr,
    output logic         o_probe_hit,
    output logic         o_bus_error,
    mem_write_if.master  axi_bus
);

    localparam int unsigned WORDS = 16;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t           state, state_n;
    logic [3:0]       beat, beat_n;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] vld;
    logic             push, pop;
    axi_w_req         bus_req;
    logic             unused_ok;

    logic [31:0] addr_q [DEPTH];
    logic [3:0]  len_q  [DEPTH];
    logic [2:0]  size_q [DEPTH];
    logic [3:0]  strb_q [DEPTH];
    logic [31:0] data_q [DEPTH][WORDS];

    assign o_req_ready      = (count < DEPTH_C);
    assign push             = i_req_valid && o_req_ready;
    assign o_write_process  = (count != '0);
    assign o_write_address  = addr_q[rd_ptr];
    assign axi_bus.axi_bus_req = bus_req;
    assign unused_ok        = ^{axi_bus.axi_bus_resp, i_probe_addr[LINE_BYTE_OFFSET-1:0]};

    // Entry payload; validity is tracked separately so storage needs no reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_q[wr_ptr] <= i_req_addr;
            len_q[wr_ptr]  <= i_req_len;
            size_q[wr_ptr] <= i_req_size;
            strb_q[wr_ptr] <= i_req_strb;
            for (int unsigned k = 0; k < WORDS; k++) begin
                data_q[wr_ptr][4'(k)] <= i_req_data[32*k +: 32];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
                vld[rd_ptr] <= 1'b0;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            beat  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    // Burst sequencing; payload fields always track the head entry.
    always_comb begin
        state_n         = state;
        beat_n          = beat;
        pop             = 1'b0;
        bus_req         = '0;
        bus_req.awid    = AXI_ID;
        bus_req.awaddr  = addr_q[rd_ptr];
        bus_req.awlen   = len_q[rd_ptr];
        bus_req.awsize  = size_q[rd_ptr];
        bus_req.awburst = 2'b01;
        bus_req.wdata   = data_q[rd_ptr][beat];
        bus_req.wstrb   = strb_q[rd_ptr];
        bus_req.wlast   = (beat == len_q[rd_ptr]);
        case (state)
            S_IDLE: begin
                if (count != '0) state_n = S_ADDR;
            end
            S_ADDR: begin
                bus_req.awvalid = 1'b1;
                if (axi_bus.axi_bus_resp.awready) begin
                    state_n = S_DATA;
                    beat_n  = '0;
                end
            end
            S_DATA: begin
                bus_req.wvalid = 1'b1;
                if (axi_bus.axi_bus_resp.wready) begin
                    if (bus_req.wlast) state_n = S_RESP;
                    else               beat_n  = beat + 4'd1;
                end
            end
            S_RESP: begin
                bus_req.bready = 1'b1;
                if (axi_bus.axi_bus_resp.bvalid) begin
                    pop     = 1'b1;
                    state_n = (count > CNT_W'(1) || push) ? S_ADDR : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Pending-write probe covers every valid entry, including the one on the bus.
    always_comb begin
        o_probe_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld[i] && (addr_q[PTR_W'(i)][31:LINE_BYTE_OFFSET] == i_probe_addr[31:LINE_BYTE_OFFSET]))
                o_probe_hit = 1'b1;
        end
    end

`ifdef MEM_WRITE_BRESP_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_bus_error <= 1'b0;
        else if (pop && (axi_bus.axi_bus_resp.bresp != 2'b00))
            o_bus_error <= 1'b1;
    end
`else
    assign o_bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_write.sv
// Randomized bench for mem_write: queue-level reference model plus directed literal scenarios.
module tb_mem_write;

    localparam int DEPTH = 2;
`ifdef MEM_WRITE_BRESP_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [511:0] data;
        logic [3:0]   strb;
        logic [2:0]   size;
        logic [3:0]   len;
        logic [31:0]  addr;
    } ent_t;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_req_valid = 1'b0;
    logic [31:0]  i_req_addr = '0;
    logic [3:0]   i_req_len = '0;
    logic [2:0]   i_req_size = '0;
    logic [3:0]   i_req_strb = '0;
    logic [511:0] i_req_data = '0;
    logic [31:0]  i_probe_addr = '0;
    wire          o_req_ready, o_write_process, o_probe_hit, o_bus_error;
    wire  [31:0]  o_write_address;

    mem_write_if bus();

    mem_write dut (
        .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
        .i_req_len(i_req_len), .i_req_size(i_req_size), .i_req_strb(i_req_strb),
        .i_req_data(i_req_data), .o_req_ready(o_req_ready), .o_write_process(o_write_process),
        .o_write_address(o_write_address), .i_probe_addr(i_probe_addr), .o_probe_hit(o_probe_hit),
        .o_bus_error(o_bus_error), .axi_bus(bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mode  = 3;   // 0 all ready, 1 random, 2 toggle wready, 3 all low, 4 no bvalid
    int bmode = 0;   // 0 OKAY, 1 random errors, 2 always SLVERR

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // AXI slave responder
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: begin bus.axi_bus_resp.awready = 1'b1; bus.axi_bus_resp.wready = 1'b1; bus.axi_bus_resp.bvalid = 1'b1; end
                1: begin
                    bus.axi_bus_resp.awready = ($urandom_range(0, 99) < 60);
                    bus.axi_bus_resp.wready  = ($urandom_range(0, 99) < 60);
                    bus.axi_bus_resp.bvalid  = ($urandom_range(0, 99) < 50);
                end
                2: begin bus.axi_bus_resp.awready = 1'b1; bus.axi_bus_resp.wready = ~bus.axi_bus_resp.wready; bus.axi_bus_resp.bvalid = 1'b1; end
                4: begin bus.axi_bus_resp.awready = 1'b1; bus.axi_bus_resp.wready = 1'b1; bus.axi_bus_resp.bvalid = 1'b0; end
                default: begin bus.axi_bus_resp.awready = 1'b0; bus.axi_bus_resp.wready = 1'b0; bus.axi_bus_resp.bvalid = 1'b0; end
            endcase
            if (bmode == 0)      bus.axi_bus_resp.bresp = 2'b00;
            else if (bmode == 2) bus.axi_bus_resp.bresp = 2'b10;
            else                 bus.axi_bus_resp.bresp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            bus.axi_bus_resp.bid = 4'($urandom);
        end
    end

    // Reference model: FIFO of entries plus per-head burst progress
    ent_t       q[$];
    ent_t       h, e;
    int         n_q;
    logic       m_aw_done = 1'b0, m_w_done = 1'b0, m_idle_gap = 1'b0, m_err = 1'b0;
    logic [3:0] m_beat = '0;
    logic       exp_aw, exp_w, exp_b, m_hit;
    logic       prev_hold = 1'b0;
    logic [31:0] prev_wdata = '0;

    initial begin
        forever begin
            @(negedge clk);
            n_q    = q.size();
            exp_aw = (n_q != 0) && !m_aw_done && !m_idle_gap;
            exp_w  = (n_q != 0) && m_aw_done && !m_w_done;
            exp_b  = (n_q != 0) && m_w_done;
            m_hit  = 1'b0;
            foreach (q[i]) if (q[i].addr[31:6] == i_probe_addr[31:6]) m_hit = 1'b1;
            chk("req_ready",     64'(o_req_ready),     64'(n_q < DEPTH));
            chk("write_process", 64'(o_write_process), 64'(n_q != 0));
            chk("probe_hit",     64'(o_probe_hit),     64'(m_hit));
            chk("bus_error",     64'(o_bus_error),     64'(m_err));
            chk("awvalid",       64'(bus.axi_bus_req.awvalid), 64'(exp_aw));
            chk("wvalid",        64'(bus.axi_bus_req.wvalid),  64'(exp_w));
            chk("bready",        64'(bus.axi_bus_req.bready),  64'(exp_b));
            if (n_q != 0) begin
                h = q[0];
                chk("write_address", 64'(o_write_address), 64'(h.addr));
                if (exp_aw) begin
                    chk("awaddr", 64'(bus.axi_bus_req.awaddr), 64'(h.addr));
                    chk("awlen",  64'(bus.axi_bus_req.awlen),  64'(h.len));
                    chk("awsize", 64'(bus.axi_bus_req.awsize), 64'(h.size));
                    chk("aw_const", 64'({bus.axi_bus_req.awburst, bus.axi_bus_req.awid, bus.axi_bus_req.awlock,
                                         bus.axi_bus_req.awcache, bus.axi_bus_req.awprot}), 64'({2'b01, 12'h000}));
                end
                if (exp_w) begin
                    chk("wdata", 64'(bus.axi_bus_req.wdata), 64'(h.data[32*m_beat +: 32]));
                    chk("wstrb", 64'(bus.axi_bus_req.wstrb), 64'(h.strb));
                    chk("wlast", 64'(bus.axi_bus_req.wlast), 64'(m_beat == h.len));
                end
            end
            if (prev_hold)
                chk("w_hold", 64'({bus.axi_bus_req.wvalid, bus.axi_bus_req.wdata}), 64'({1'b1, prev_wdata}));
            prev_hold  = bus.axi_bus_req.wvalid && !bus.axi_bus_resp.wready && !i_rst;
            prev_wdata = bus.axi_bus_req.wdata;

            if (i_rst) begin
                q.delete();
                m_aw_done = 1'b0; m_w_done = 1'b0; m_idle_gap = 1'b0; m_err = 1'b0; m_beat = '0;
            end else begin
                m_idle_gap = 1'b0;
                if (exp_aw && bus.axi_bus_resp.awready) m_aw_done = 1'b1;
                if (exp_w && bus.axi_bus_resp.wready) begin
                    if (m_beat == h.len) m_w_done = 1'b1;
                    else                 m_beat = m_beat + 4'd1;
                end
                if (exp_b && bus.axi_bus_resp.bvalid) begin
                    if (ERR_EN && bus.axi_bus_resp.bresp != 2'b00) m_err = 1'b1;
                    q.delete(0);
                    m_aw_done = 1'b0; m_w_done = 1'b0; m_beat = '0;
                end
                if (i_req_valid && n_q < DEPTH) begin
                    if (n_q == 0) m_idle_gap = 1'b1;
                    e.addr = i_req_addr; e.len = i_req_len; e.size = i_req_size;
                    e.strb = i_req_strb; e.data = i_req_data;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; holds valid for exactly the accepting cycle.
    task automatic push(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] base);
        int n = 0;
        while (!o_req_ready && n < 200) begin sync(); n++; end
        chk("push_accept_timeout", 64'(n < 200), 64'(1));
        i_req_valid = 1'b1; i_req_addr = addr; i_req_len = len;
        i_req_size = 3'b010; i_req_strb = 4'hF;
        for (int k = 0; k < 16; k++) i_req_data[32*k +: 32] = base + 32'(k);
        sync();
        i_req_valid = 1'b0;
    endtask

    task automatic wait_aw(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.axi_bus_req.awvalid && n < 50);
    endtask

    task automatic drain();
        int n = 0;
        while (o_write_process && n < 600) begin @(negedge clk); n++; end
        chk("drain_timeout", 64'(n < 600), 64'(1));
    endtask

    int          lat, nb, last_idx, nlast, nret;
    logic [31:0] ret_addr [3];
    logic [31:0] last_addr = 32'h0000_1000;

    initial begin
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk("rst_awvalid", 64'(bus.axi_bus_req.awvalid), 64'(0));
        chk("rst_wvalid",  64'(bus.axi_bus_req.wvalid),  64'(0));
        chk("rst_bready",  64'(bus.axi_bus_req.bready),  64'(0));
        chk("rst_ready",   64'(o_req_ready),     64'(1));
        chk("rst_process", 64'(o_write_process), 64'(0));
        chk("rst_hit",     64'(o_probe_hit),     64'(0));
        chk("rst_error",   64'(o_bus_error),     64'(0));

        // Full 16-beat line with an always-ready slave
        sync(); mode = 0;
        push(32'h1FC0_0040, 4'd15, 32'hA000_0000);
        wait_aw(lat);
        chk("aw_latency", 64'(lat), 64'(2));
        nb = 0; last_idx = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.axi_bus_req.wvalid && bus.axi_bus_resp.wready) begin
                chk("line_word", 64'(bus.axi_bus_req.wdata), 64'(32'hA000_0000 + 32'(nb)));
                if (bus.axi_bus_req.wlast) last_idx = nb;
                nb++;
            end
            if (bus.axi_bus_req.bready && bus.axi_bus_resp.bvalid) break;
        end
        chk("line_beats", 64'(nb), 64'(16));
        chk("line_wlast_idx", 64'(last_idx), 64'(15));
        @(negedge clk);
        chk("line_process_falls", 64'(o_write_process), 64'(0));

        // Queue full, push while head retires, FIFO order
        sync(); mode = 3;
        push(32'h0000_0100, 4'd1, 32'h1000_0000);
        push(32'h0000_2000, 4'd0, 32'h2000_0000);
        @(negedge clk);
        chk("full_ready_low", 64'(o_req_ready), 64'(0));
        sync(); mode = 0; nret = 0;
        fork
            push(32'h0000_3040, 4'd2, 32'h3000_0000);
            for (int c = 0; c < 200 && nret < 3; c++) begin
                @(negedge clk);
                if (bus.axi_bus_req.bready && bus.axi_bus_resp.bvalid) begin
                    ret_addr[nret] = o_write_address;
                    nret++;
                end
            end
        join
        chk("retire_count", 64'(nret), 64'(3));
        chk("retire_0", 64'(ret_addr[0]), 64'(32'h0000_0100));
        chk("retire_1", 64'(ret_addr[1]), 64'(32'h0000_2000));
        chk("retire_2", 64'(ret_addr[2]), 64'(32'h0000_3040));
        drain();

        // wready toggling during a 4-beat burst
        sync(); mode = 2;
        push(32'h0000_4000, 4'd3, 32'h4000_0000);
        nb = 0; nlast = 0; last_idx = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.axi_bus_req.wvalid && bus.axi_bus_resp.wready) begin
                if (bus.axi_bus_req.wlast) begin nlast++; last_idx = nb; end
                nb++;
            end
            if (bus.axi_bus_req.bready && bus.axi_bus_resp.bvalid) break;
        end
        chk("toggle_beats", 64'(nb), 64'(4));
        chk("toggle_wlast_count", 64'(nlast), 64'(1));
        chk("toggle_wlast_idx", 64'(last_idx), 64'(3));
        drain();

        // Probe against a parked entry
        sync(); mode = 3;
        push(32'h0000_1000, 4'd0, 32'h5000_0000);
        i_probe_addr = 32'h0000_103C;
        @(negedge clk);
        chk("probe_same_line", 64'(o_probe_hit), 64'(1));
        sync(); i_probe_addr = 32'h0000_1040;
        @(negedge clk);
        chk("probe_next_line", 64'(o_probe_hit), 64'(0));
        sync(); mode = 0;
        drain();

        // Reset in the middle of the data phase at beat 5
        sync(); mode = 4;
        push(32'h0000_8000, 4'd15, 32'h6000_0000);
        wait_aw(lat);
        repeat (6) @(posedge clk);
        #1 i_rst = 1'b1;
        @(negedge clk);
        chk("mid_beat5_data", 64'(bus.axi_bus_req.wdata), 64'(32'h6000_0005));
        sync(); i_rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_wvalid",  64'(bus.axi_bus_req.wvalid), 64'(0));
        chk("mid_rst_awvalid", 64'(bus.axi_bus_req.awvalid), 64'(0));
        chk("mid_rst_process", 64'(o_write_process), 64'(0));
        chk("mid_rst_ready",   64'(o_req_ready), 64'(1));

        // Error response, then a clean one: flag is sticky when enabled
        sync(); mode = 0; bmode = 2;
        push(32'h0000_9000, 4'd0, 32'h7000_0000);
        drain();
        @(negedge clk);
        chk("bresp_error", 64'(o_bus_error), 64'(ERR_EN));
        sync(); bmode = 0;
        push(32'h0000_9100, 4'd1, 32'h7100_0000);
        drain();
        @(negedge clk);
        chk("bresp_error_sticky", 64'(o_bus_error), 64'(ERR_EN));

        // Randomized traffic
        sync(); mode = 1; bmode = 1;
        for (int c = 0; c < 1500; c++) begin
            i_rst       = ($urandom_range(0, 399) == 0);
            i_req_valid = ($urandom_range(0, 99) < 35);
            i_req_addr  = $urandom;
            i_req_len   = 4'($urandom);
            i_req_size  = 3'($urandom);
            i_req_strb  = 4'($urandom);
            for (int k = 0; k < 16; k++) i_req_data[32*k +: 32] = $urandom;
            if (i_req_valid) last_addr = i_req_addr;
            i_probe_addr = ($urandom_range(0, 1) == 1) ? {last_addr[31:6], 6'($urandom)} : $urandom;
            sync();
        end
        i_rst = 1'b0; i_req_valid = 1'b0; mode = 0; bmode = 0;
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
